// File: rtl/alu_arith_pkg.sv
// Shared types for the ARMv4 arithmetic unit: op codes, FSM states and
// bit positions of the packed N/Z/C/V flag register.
package alu_arith_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_ADC = 3'd1,
      OP_SUB = 3'd2,
      OP_SBC = 3'd3,
      OP_RSB = 3'd4,
      OP_MUL = 3'd5
   } alu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } alu_state_e;

   localparam int FLAG_V = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 3;
   localparam int FLAG_W = 4;

endpackage

// File: rtl/alu_addsub_core.sv
// Combinational N-bit adder with per-operand inversion, carry-in, carry-out
// and two's-complement overflow taken from the (possibly inverted) adder inputs.
module alu_addsub_core #(
   parameter int N = 32
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         inv_x,
   input  logic         inv_y,
   input  logic         carry_in,
   output logic [N-1:0] sum,
   output logic         carry_out,
   output logic         overflow
);

   logic [N-1:0] x_eff;
   logic [N-1:0] y_eff;

   assign x_eff = inv_x ? ~x : x;
   assign y_eff = inv_y ? ~y : y;

   assign {carry_out, sum} = {1'b0, x_eff} + {1'b0, y_eff} + {{N{1'b0}}, carry_in};

   assign overflow = (x_eff[N-1] == y_eff[N-1]) && (sum[N-1] != x_eff[N-1]);

endmodule

// File: rtl/alu_arith_seq.sv
// Registered ARM arithmetic unit: single-cycle add-class ops and an N-cycle
// shift-add multiply sharing one adder, with a start/busy/done handshake.
module alu_arith_seq
   import alu_arith_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic [N-1:0] result,
   output logic         flag_n,
   output logic         flag_z,
   output logic         flag_c,
   output logic         flag_v,
   output logic         busy,
   output logic         done
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

   alu_state_e        state_reg;
   alu_state_e        state_next;
   logic [CW-1:0]     cnt_reg;
   logic [N-1:0]      mcand_reg;
   logic [N-1:0]      mplier_reg;
   logic [N-1:0]      acc_reg;
   logic [N-1:0]      result_reg;
   logic [FLAG_W-1:0] flags_reg;
   logic              done_reg;

   alu_op_e      op_sel;
   logic [N-1:0] add_x;
   logic [N-1:0] add_y;
   logic         add_inv_x;
   logic         add_inv_y;
   logic         add_cin;
   logic [N-1:0] add_sum;
   logic         add_cout;
   logic         add_ovf;
   logic         do_arith;
   logic         do_nop;
   logic         load_mul;
   logic         mul_step;
   logic         mul_last;

   assign op_sel = alu_op_e'(op);

   alu_addsub_core #(.N(N)) u_core (
      .x         (add_x),
      .y         (add_y),
      .inv_x     (add_inv_x),
      .inv_y     (add_inv_y),
      .carry_in  (add_cin),
      .sum       (add_sum),
      .carry_out (add_cout),
      .overflow  (add_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // In IDLE the adder sees the live operands; in MUL it accumulates the
   // shifted multiplicand whenever the current multiplier LSB is set.
   always_comb begin
      state_next = state_reg;
      add_x      = a;
      add_y      = b;
      add_inv_x  = 1'b0;
      add_inv_y  = 1'b0;
      add_cin    = 1'b0;
      do_arith   = 1'b0;
      do_nop     = 1'b0;
      load_mul   = 1'b0;
      mul_step   = 1'b0;
      mul_last   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               case (op_sel)
                  OP_ADD: do_arith = 1'b1;
                  OP_ADC: begin
                     add_cin  = c_in;
                     do_arith = 1'b1;
                  end
                  OP_SUB: begin
                     add_inv_y = 1'b1;
                     add_cin   = 1'b1;
                     do_arith  = 1'b1;
                  end
                  OP_SBC: begin
                     add_inv_y = 1'b1;
                     add_cin   = c_in;
                     do_arith  = 1'b1;
                  end
                  OP_RSB: begin
                     add_inv_x = 1'b1;
                     add_cin   = 1'b1;
                     do_arith  = 1'b1;
                  end
                  OP_MUL: begin
                     load_mul   = 1'b1;
                     state_next = ST_MUL;
                  end
                  default: do_nop = 1'b1;
               endcase
            end
         end
         ST_MUL: begin
            add_x    = acc_reg;
            add_y    = mplier_reg[0] ? mcand_reg : '0;
            mul_step = 1'b1;
            if (cnt_reg == LAST_ITER) begin
               mul_last   = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         result_reg <= '0;
         flags_reg  <= '0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (load_mul) begin
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
         end
         if (mul_step) begin
            acc_reg    <= add_sum;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CW'(1);
            if (mul_last) begin
               cnt_reg           <= '0;
               result_reg        <= add_sum;
               flags_reg[FLAG_N] <= add_sum[N-1];
               flags_reg[FLAG_Z] <= (add_sum == '0);
               done_reg          <= 1'b1;
            end
         end
         if (do_arith) begin
            result_reg        <= add_sum;
            flags_reg[FLAG_N] <= add_sum[N-1];
            flags_reg[FLAG_Z] <= (add_sum == '0);
            flags_reg[FLAG_C] <= add_cout;
            flags_reg[FLAG_V] <= add_ovf;
            done_reg          <= 1'b1;
         end
         if (do_nop) begin
            done_reg <= 1'b1;
         end
      end
   end

   assign result = result_reg;
   assign flag_n = flags_reg[FLAG_N];
   assign flag_z = flags_reg[FLAG_Z];
   assign flag_c = flags_reg[FLAG_C];
   assign flag_v = flags_reg[FLAG_V];
   assign busy   = (state_reg == ST_MUL);
   assign done   = done_reg;

endmodule
